// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: opcode encodings, legality check, response FSM states.
package alu_pkg;

    localparam int unsigned OPW = 6;

    localparam logic [OPW-1:0] OP_ADD = 6'b100000;
    localparam logic [OPW-1:0] OP_SUB = 6'b100010;
    localparam logic [OPW-1:0] OP_AND = 6'b100100;
    localparam logic [OPW-1:0] OP_OR  = 6'b100101;
    localparam logic [OPW-1:0] OP_SLT = 6'b101010;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ALU32Bit.sv
// Combinational ALU: add, subtract, and, or, signed set-less-than; zero for unknown functions.
module ALU32Bit
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic [OPW-1:0] func_i,
    output logic [N-1:0]   result_o
);

    always_comb begin
        result_o = '0;
        case (func_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_SLT:  result_o = N'($signed(a_i) < $signed(b_i));
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_grant_i, wrapping around.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic            grant_valid_o,
    output logic [IDW-1:0]  grant_idx_o
);

    logic [IDW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest requester overrides.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = IDW'((int'(last_grant_i) + k) % int'(NREQ));
            if (req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU32Bit among NREQ requesters with round-robin arbitration
// and a single registered response slot that supports one operation per cycle.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int unsigned N    = 32,
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*6-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_illegal,
    output logic [31:0]       ops_count
);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] rsp_id_q;
    logic [N-1:0]   rsp_data_q;
    logic           rsp_illegal_q;
    logic [31:0]    ops_count_q;

    logic           can_issue;
    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic           fire;
    logic [N-1:0]   alu_a, alu_b, alu_y;
    logic [OPW-1:0] alu_op;
    logic           op_legal;

    assign can_issue = (state_q == EMPTY) || rsp_ready;
    assign fire      = can_issue && grant_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i         (req_valid),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign alu_a    = req_a[int'(grant_idx)*N +: N];
    assign alu_b    = req_b[int'(grant_idx)*N +: N];
    assign alu_op   = req_op[int'(grant_idx)*OPW +: OPW];
    assign op_legal = is_legal_op(alu_op);

    ALU32Bit #(.N(N)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .func_i   (alu_op),
        .result_o (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (fire) state_d = FULL;
            FULL:    if (rsp_ready && !fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (fire) req_ready[grant_idx] = 1'b1;
    end

    // Response slot and priority pointer advance only on an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q  <= IDW'(NREQ - 1);
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
            ops_count_q   <= '0;
        end else if (fire) begin
            last_grant_q  <= grant_idx;
            rsp_id_q      <= grant_idx;
            rsp_data_q    <= op_legal ? alu_y : '0;
            rsp_illegal_q <= !op_legal;
            ops_count_q   <= (ops_count_q == 32'hFFFF_FFFF) ? ops_count_q : ops_count_q + 32'd1;
        end
    end

    assign rsp_valid   = (state_q == FULL);
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_illegal = rsp_illegal_q;
    assign ops_count   = ops_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand-built corner sequences, and
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] SLT = 6'b101010;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*6-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_data;
    logic              rsp_illegal;
    logic [31:0]       ops_count;

    alu_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal),
        .ops_count   (ops_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT outputs captured at the falling edge of the most recent cycle
    logic [NREQ-1:0] s_req_ready;
    logic            s_rsp_valid;
    logic [IDW-1:0]  s_rsp_id;
    logic [N-1:0]    s_rsp_data;
    logic            s_rsp_illegal;
    logic [31:0]     s_ops_count;
    int              last_winner;

    // Reference model: one response slot plus a rotating priority pointer
    bit          m_full;
    int          m_id;
    logic [31:0] m_data;
    bit          m_ill;
    int          m_last;
    logic [31:0] m_count;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[8];

    function automatic bit ref_legal(input logic [5:0] op);
        return (op == ADD) || (op == SUB) || (op == AND) || (op == OR) || (op == SLT);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_id    = 0;
        m_data  = '0;
        m_ill   = 1'b0;
        m_last  = NREQ - 1;
        m_count = '0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] op);
        req_valid[i]     = v;
        req_a[i*N +: N]  = a;
        req_b[i*N +: N]  = b;
        req_op[i*6 +: 6] = op;
    endtask

    // One clock: sample and compare at the falling edge, advance the model, return after the rising edge.
    task automatic cycle();
        int              win;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        s_req_ready   = req_ready;
        s_rsp_valid   = rsp_valid;
        s_rsp_id      = rsp_id;
        s_rsp_data    = rsp_data;
        s_rsp_illegal = rsp_illegal;
        s_ops_count   = ops_count;

        win = -1;
        if (!m_full || rsp_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_last + k) % NREQ;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;

        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (m_full) begin
            check("rsp_id", 64'(rsp_id), 64'(m_id));
            check("rsp_data", 64'(rsp_data), 64'(m_data));
            check("rsp_illegal", 64'(rsp_illegal), 64'(m_ill));
        end
        check("ops_count", 64'(ops_count), 64'(m_count));
        last_winner = win;

        if (rst) begin
            model_reset();
        end else if (win >= 0) begin
            m_full = 1'b1;
            m_id   = win;
            m_data = ref_alu(req_a[win*N +: N], req_b[win*N +: N], req_op[win*6 +: 6]);
            m_ill  = !ref_legal(req_op[win*6 +: 6]);
            m_last = win;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          eg[5];
        int          rid[5];
        logic [31:0] rdat[5];
        logic [31:0] held;
        logic [31:0] cnt0;
        logic [3:0]  one;
        int          waits[NREQ];

        vecs[0] = '{0, 32'd10,        32'd5,         ADD,      32'd15,        1'b0};
        vecs[1] = '{1, 32'd3,         32'd5,         SUB,      32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{2, 32'hF0F0_F0F0, 32'hFF00_FF00, AND,      32'hF000_F000, 1'b0};
        vecs[3] = '{3, 32'hF0F0_F0F0, 32'h0F0F_0000, OR,       32'hFFFF_F0F0, 1'b0};
        vecs[4] = '{1, 32'hFFFF_FFFF, 32'd1,         SLT,      32'd1,         1'b0};
        vecs[5] = '{2, 32'd1,         32'hFFFF_FFFF, SLT,      32'd0,         1'b0};
        vecs[6] = '{3, 32'd5,         32'd6,         6'h3F,    32'd0,         1'b1};
        vecs[7] = '{0, 32'hFFFF_FFFF, 32'd1,         ADD,      32'd0,         1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        check("reset_rsp_valid", 64'(s_rsp_valid), 64'(0));
        check("reset_rsp_id", 64'(s_rsp_id), 64'(0));
        check("reset_rsp_data", 64'(s_rsp_data), 64'(0));
        check("reset_rsp_illegal", 64'(s_rsp_illegal), 64'(0));
        check("reset_ops_count", 64'(s_ops_count), 64'(0));

        // Single request from requester 0
        set_req(0, 1'b1, 32'd10, 32'd5, ADD);
        cycle();
        check("single_grant", 64'(s_req_ready), 64'(4'b0001));
        req_valid = '0;
        cycle();
        check("single_valid", 64'(s_rsp_valid), 64'(1));
        check("single_data", 64'(s_rsp_data), 64'(15));
        check("single_id", 64'(s_rsp_id), 64'(0));
        check("single_illegal", 64'(s_rsp_illegal), 64'(0));
        check("single_count", 64'(s_ops_count), 64'(1));

        // Function table, one requester at a time
        for (int k = 0; k < 8; k++) begin
            req_valid = '0;
            set_req(vecs[k].id, 1'b1, vecs[k].a, vecs[k].b, vecs[k].op);
            cycle();
            one = 4'b0001;
            check("vec_grant", 64'(s_req_ready), 64'(one << vecs[k].id));
            req_valid = '0;
            cycle();
            check("vec_data", 64'(s_rsp_data), 64'(vecs[k].exp_data));
            check("vec_illegal", 64'(s_rsp_illegal), 64'(vecs[k].exp_ill));
            check("vec_id", 64'(s_rsp_id), 64'(vecs[k].id));
        end

        // All four requesters valid back to back
        do_reset();
        set_req(0, 1'b1, 32'd10, 32'd5, SUB);
        set_req(1, 1'b1, 32'd10, 32'd5, AND);
        set_req(2, 1'b1, 32'd10, 32'd5, OR);
        set_req(3, 1'b1, 32'd10, 32'd5, SLT);
        eg   = '{0, 1, 2, 3, 0};
        rid  = '{0, 1, 2, 3, 0};
        rdat = '{32'd5, 32'd0, 32'd15, 32'd0, 32'd5};
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = '0;
            cycle();
            one = 4'b0001;
            if (k < 5) check("rr_grant", 64'(s_req_ready), 64'(one << eg[k]));
            if (k >= 1) begin
                check("rr_rsp_valid", 64'(s_rsp_valid), 64'(1));
                check("rr_rsp_id", 64'(s_rsp_id), 64'(rid[k-1]));
                check("rr_rsp_data", 64'(s_rsp_data), 64'(rdat[k-1]));
            end
        end

        // Backpressure: response held while requesters 1 and 2 wait
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(3, 1'b1, 32'd7, 32'd8, ADD);
        cycle();
        check("bp_first_grant", 64'(s_req_ready), 64'(4'b1000));
        req_valid = '0;
        set_req(1, 1'b1, 32'd1, 32'd1, ADD);
        set_req(2, 1'b1, 32'd6, 32'd9, OR);
        for (int j = 0; j < 3; j++) begin
            cycle();
            check("bp_ready_low", 64'(s_req_ready), 64'(0));
            check("bp_valid", 64'(s_rsp_valid), 64'(1));
            check("bp_id", 64'(s_rsp_id), 64'(3));
            check("bp_data", 64'(s_rsp_data), 64'(15));
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_release_grant", 64'(s_req_ready), 64'(4'b0010));
        check("bp_release_id", 64'(s_rsp_id), 64'(3));
        req_valid[1] = 1'b0;
        cycle();
        check("bp_next_data", 64'(s_rsp_data), 64'(2));
        check("bp_next_grant", 64'(s_req_ready), 64'(4'b0100));
        req_valid = '0;
        cycle();
        cnt0 = s_ops_count;

        // Illegal opcode from requester 2
        set_req(2, 1'b1, 32'd123, 32'd456, 6'b000000);
        cycle();
        req_valid = '0;
        cycle();
        check("ill_flag", 64'(s_rsp_illegal), 64'(1));
        check("ill_data", 64'(s_rsp_data), 64'(0));
        check("ill_id", 64'(s_rsp_id), 64'(2));
        check("ill_count", 64'(s_ops_count), 64'(cnt0 + 32'd1));

        // Reset while a response is held and ops_count is 7
        do_reset();
        set_req(0, 1'b1, 32'd1, 32'd1, ADD);
        repeat (7) cycle();
        req_valid = '0;
        rsp_ready = 1'b0;
        cycle();
        check("pre_rst_count", 64'(s_ops_count), 64'(7));
        check("pre_rst_valid", 64'(s_rsp_valid), 64'(1));
        held = s_rsp_data;
        check("pre_rst_data", 64'(held), 64'(2));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'd4, 32'd4, ADD);
        set_req(3, 1'b1, 32'd9, 32'd1, SUB);
        cycle();
        check("post_rst_valid", 64'(s_rsp_valid), 64'(0));
        check("post_rst_count", 64'(s_ops_count), 64'(0));
        check("post_rst_data", 64'(s_rsp_data), 64'(0));
        check("post_rst_grant", 64'(s_req_ready), 64'(4'b0001));

        // Wrap: 3 granted, then 1 and 3 both valid
        cycle();
        check("wrap_grant3", 64'(s_req_ready), 64'(4'b1000));
        req_valid = '0;
        set_req(1, 1'b1, 32'd2, 32'd3, ADD);
        set_req(3, 1'b1, 32'd9, 32'd1, SUB);
        cycle();
        check("wrap_grant1", 64'(s_req_ready), 64'(4'b0010));
        cycle();
        check("wrap_grant3b", 64'(s_req_ready), 64'(4'b1000));
        req_valid = '0;
        cycle();

        // Randomized traffic against the reference model
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 299) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || s_req_ready[i]) begin
                    logic [31:0] a, b;
                    logic [5:0]  op;
                    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
                    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
                    case ($urandom_range(0, 5))
                        0:       op = ADD;
                        1:       op = SUB;
                        2:       op = AND;
                        3:       op = OR;
                        4:       op = SLT;
                        default: op = 6'($urandom_range(0, 63));
                    endcase
                    set_req(i, 1'($urandom_range(0, 1)), a, b, op);
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
            if (rst) begin
                for (int i = 0; i < NREQ; i++) waits[i] = 0;
            end else if (last_winner >= 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (i == last_winner) begin
                        check("fair_wait", 64'(waits[i] < NREQ), 64'(1));
                        waits[i] = 0;
                    end else if (req_valid[i]) begin
                        waits[i]++;
                    end else begin
                        waits[i] = 0;
                    end
                end
            end else begin
                for (int i = 0; i < NREQ; i++) if (!req_valid[i]) waits[i] = 0;
            end
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Round-robin arbiter that time-shares one ALU32Bit instance among NREQ requesters.
- Each requester presents operands A/B and a 6-bit function opcode with a valid/ready handshake.
- The winner's operation is issued to the ALU. The result is captured in a single output register and returned with the requester ID over a valid/ready response channel.
- It sits between the issue logic of multiple pipeline clients and the shared ALU datapath.

Parameters:
- N, 32, datapath width passed to ALU32Bit
- NREQ, 4, number of requesters (2..16); the ID width IDW = clog2(NREQ) is a derived localparam

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  bit i: requester i has an operation pending
- req_ready  output  NREQ  bit i: requester i is granted this cycle (combinational, one-hot or zero)
- req_a  input  NREQ*N  operand A per requester, slice i = bits [i*N +: N]
- req_b  input  NREQ*N  operand B per requester, same slicing
- req_op  input  NREQ*6  opcode per requester, slice i = bits [i*6 +: 6]
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  IDW  index of the requester that owns the response
- rsp_data  output  N  ALU result
- rsp_illegal  output  1  opcode was not a supported function
- ops_count  output  32  saturating count of accepted operations, illegal ones included

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_illegal=0, ops_count=0, last_grant=NREQ-1 (requester 0 has top priority first).
- FSM has two states, EMPTY and FULL, equivalent to rsp_valid.
- can_issue = EMPTY, or (FULL and rsp_ready).
- Arbitration:
  - Search starts at (last_grant+1) mod NREQ, wrapping.
  - The first i with req_valid[i]=1 wins.
  - req_ready[winner]=1 only when can_issue; all other bits are 0.
- Transfer fires when req_valid[i] and req_ready[i] are both high.
- On transfer:
  - The winner's A/B/op are muxed to ALU32Bit.
  - The result is registered, giving 1-cycle latency: rsp_valid=1 on the next cycle.
  - rsp_id=winner, last_grant=winner, ops_count increments (holds at 0xFFFFFFFF).
- Supported opcodes are ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - For any other opcode: rsp_illegal=1, rsp_data=0, and the ALU output is ignored.
- Transitions:
  - EMPTY with a transfer goes to FULL.
  - FULL with rsp_ready and a transfer stays FULL with the new result, so throughput is 1 op/cycle.
  - FULL with rsp_ready and no transfer goes to EMPTY.
  - FULL without rsp_ready holds all rsp_* outputs stable and forces req_ready=0.
- Fairness: a continuously-valid requester is granted within NREQ transfers.
- last_grant updates only on a transfer; idle cycles do not rotate priority.
- Requesters must hold A/B/op stable while req_valid=1 and until their req_ready.
  - Dropping req_valid before grant is legal: the request is simply withdrawn.
- rst mid-operation: the next cycle shows reset values, and any held response is discarded without handshake.
- If no req_valid bits are set, nothing issues and state is unchanged apart from draining.

Decomposition:
Package alu_pkg holds:
- the opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT
- a function is_legal_op(op)
- the state enum typedef (EMPTY/FULL)

Sub-modules:
- rr_pick, a combinational round-robin priority picker (inputs: req vector, last_grant; outputs: grant_valid, grant_idx). It is reusable by other shared-resource arbiters.
- The existing ALU32Bit, instantiated once with N.

Test Plan:
- Single request: requester 0, A=10, B=5, op=100000, rsp_ready=1 → req_ready[0] in cycle 0; rsp_valid cycle 1 with rsp_data=15, rsp_id=0, rsp_illegal=0, ops_count=1.
- All 4 requesters valid continuously, ops SUB/AND/OR/SLT on A=10, B=5, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; responses 5, 0, 15, 0 with matching IDs; no bubbles.
- Backpressure: FULL with rsp_ready=0 for 3 cycles while requesters 1 and 2 are valid → rsp_* stable and req_ready=0 for all 3 cycles. On rsp_ready=1, requester 1 is granted in that same cycle.
- Illegal opcode 000000 from requester 2 → rsp_illegal=1, rsp_data=0, rsp_id=2, ops_count increments.
- Reset asserted while FULL with ops_count=7 → next cycle rsp_valid=0, ops_count=0. With requesters 0 and 3 then valid, requester 0 wins first.
- Fairness/wrap with NREQ=4: requester 3 is granted last, then requesters 3 and 1 are both valid → 1 wins, then 3; requester 3 never waits more than 4 transfers.
